// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - shared types and helpers for the OBI atomic-aware arbiter
//
// Contents:
//   arb_state_e : arbiter FSM state (ARB = normal round-robin, LOCKED = atomic in flight)
//   sel_width() : index width for a count of items, never less than one bit
package obi_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - synchronous FIFO holding transaction IDs in issue order
//
// Ports:
//   clk_i   : clock, rising edge
//   flush_i : synchronous clear of pointers and count (used as the reset)
//   push_i  : write data_i; accepted when not full or when popping the same cycle
//   data_i  : entry to write
//   pop_i   : drop the head entry; ignored when empty
//   data_o  : head entry
//   full_o  : DEPTH entries held
//   empty_o : no entries held
//   usage_o : number of entries held (0..DEPTH)
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_W:0]       usage_o
);

  localparam int unsigned CntW = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     wptr_q;
  logic [ADDR_W-1:0]     rptr_q;
  logic [CntW-1:0]       cnt_q;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rptr_q];
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= inc(wptr_q);
      end
      if (do_pop) begin
        rptr_q <= inc(rptr_q);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/obi_amo_arbiter.sv
// rtl/obi_amo_arbiter.sv - round-robin OBI arbiter that serialises atomic operations
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   req_i        : per-port OBI req
//   atop_i       : per-port flag, pending request is an atomic
//   gnt_o        : per-port OBI gnt, one-hot or zero
//   sel_o        : A-channel mux select (winning port)
//   mgr_req_o    : req toward the shared subordinate
//   mgr_gnt_i    : gnt from the shared subordinate
//   mgr_rvalid_i : in-order rvalid from the subordinate
//   rvalid_o     : rvalid routed to the originating port, one-hot or zero
//   rsel_o       : R-channel demux select (ID FIFO head)
//   locked_o     : an atomic is outstanding
module obi_amo_arbiter
  import obi_pkg::*;
#(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned MaxTrans = 4,
  parameter int unsigned SelWidth = sel_width(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_i,
  input  logic [NumReq-1:0]   atop_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [SelWidth-1:0] sel_o,
  output logic                mgr_req_o,
  input  logic                mgr_gnt_i,
  input  logic                mgr_rvalid_i,
  output logic [NumReq-1:0]   rvalid_o,
  output logic [SelWidth-1:0] rsel_o,
  output logic                locked_o
);

  localparam int unsigned AddrW = sel_width(MaxTrans);

  arb_state_e          state_q, state_d;
  logic [SelWidth-1:0] ptr_q;
  logic                held_v_q;
  logic [SelWidth-1:0] held_idx_q;
  logic [AddrW:0]      older_q, older_d;
  logic [SelWidth-1:0] scan_win, cand, win, head;
  logic                found;
  logic                fifo_full, fifo_empty;
  logic [AddrW:0]      usage;
  logic                pop, issue_ok, handshake;

  // First requester at or after the priority pointer, wrapping past NumReq-1.
  always_comb begin
    scan_win = ptr_q;
    cand     = ptr_q;
    found    = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req_i[cand]) begin
        found    = 1'b1;
        scan_win = cand;
      end
      cand = (cand == SelWidth'(NumReq - 1)) ? '0 : cand + 1'b1;
    end
  end

  // A port that was selected but not yet granted keeps the selection, so a
  // late-arriving higher-priority port cannot cut in, including while an
  // atomic waits for older responses to drain.
  assign win = (held_v_q && req_i[held_idx_q]) ? held_idx_q : scan_win;

  assign pop       = mgr_rvalid_i & ~fifo_empty & ~rst_i;
  assign issue_ok  = (state_q == ARB) & ~(fifo_full & ~pop)
                   & ~(atop_i[win] & ~fifo_empty) & ~rst_i;
  assign mgr_req_o = (|req_i) & issue_ok;
  assign handshake = mgr_req_o & mgr_gnt_i;
  assign gnt_o     = handshake ? (NumReq'(1) << win) : '0;
  assign sel_o     = rst_i ? '0 : win;
  assign rvalid_o  = pop ? (NumReq'(1) << head) : '0;
  assign rsel_o    = rst_i ? '0 : head;
  assign locked_o  = (state_q == LOCKED) & ~rst_i;

  fifo_v3 #(
    .DATA_WIDTH (SelWidth),
    .DEPTH      (MaxTrans),
    .ADDR_W     (AddrW)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .flush_i (rst_i),
    .push_i  (handshake),
    .data_i  (win),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (usage)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      held_v_q   <= 1'b0;
      held_idx_q <= '0;
      older_q    <= '0;
    end else begin
      state_q    <= state_d;
      older_q    <= older_d;
      if (handshake) begin
        ptr_q <= (win == SelWidth'(NumReq - 1)) ? '0 : win + 1'b1;
      end
      held_v_q   <= (|req_i) & ~handshake;
      held_idx_q <= win;
    end
  end

  // older counts entries queued ahead of the atomic; only the pop that finds
  // it at zero retires the atomic itself.
  always_comb begin
    state_d = state_q;
    older_d = older_q;
    case (state_q)
      ARB: begin
        if (handshake && atop_i[win]) begin
          state_d = LOCKED;
          older_d = usage;
        end
      end
      LOCKED: begin
        if (pop) begin
          if (older_q == '0) begin
            state_d = ARB;
          end else begin
            older_d = older_q - 1'b1;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  a_rvalid_with_entry : assert property (
    @(posedge clk_i) disable iff (rst_i) mgr_rvalid_i |-> !fifo_empty);

  for (genvar k = 0; k < NumReq; k++) begin : gen_req_stable
    a_req_held : assert property (
      @(posedge clk_i) disable iff (rst_i) (req_i[k] && !gnt_o[k]) |=> req_i[k]);
  end

endmodule

// File: doc/obi_amo_arbiter.md
OBI_AMO_ARBITER -- requirements
Module: obi_amo_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requester ports (2..16).
REQ-002 SHALL have parameter MaxTrans, default 4, maximum outstanding granted transactions (power of two, 1..16).
REQ-003 SHALL have parameter SelWidth, default $clog2(NumReq) (minimum 1), width of the port index.
REQ-004 SHALL have clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have rst_i, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have req_i, input, NumReq, per-port OBI req.
REQ-007 SHALL have atop_i, input, NumReq, per-port flag: the pending request carries a non-zero atop.
REQ-008 SHALL have gnt_o, output, NumReq, per-port OBI gnt, one-hot or zero.
REQ-009 SHALL have sel_o, output, SelWidth, A-channel mux select for the datapath; valid whenever mgr_req_o=1.
REQ-010 SHALL have mgr_req_o, output, 1, req toward the shared subordinate port.
REQ-011 SHALL have mgr_gnt_i, input, 1, gnt from the shared subordinate port.
REQ-012 SHALL have mgr_rvalid_i, input, 1, rvalid from the subordinate; responses are in order.
REQ-013 SHALL have rvalid_o, output, NumReq, rvalid routed to the originating port, one-hot or zero.
REQ-014 SHALL have rsel_o, output, SelWidth, R-channel demux select, equal to the FIFO head index.
REQ-015 SHALL have locked_o, output, 1, high while an atomic is outstanding.

Function
REQ-016 SHALL arbitrate round-robin: the winner is the first requesting port at or after the priority pointer, scanning upward with wrap-around from NumReq-1 to 0.
REQ-017 SHALL advance the priority pointer to winner+1 (mod NumReq) only on a handshake cycle (mgr_req_o & mgr_gnt_i); otherwise it holds.
REQ-018 SHALL drive mgr_req_o = OR of req_i, gated by the stall conditions below; sel_o = winner; gnt_o[winner] = mgr_gnt_i & mgr_req_o, combinationally in the same cycle.
REQ-019 SHALL keep the selection stable while the winner's req_i stays high and no handshake has occurred; no re-arbitration mid-request.
REQ-020 SHALL push the winner index into an ID FIFO of depth MaxTrans on each handshake.
REQ-021 SHALL pop the FIFO on each cycle with mgr_rvalid_i=1, and drive rvalid_o[head] = mgr_rvalid_i and rsel_o = head.
REQ-022 SHALL stall (mgr_req_o=0, gnt_o=0) when the FIFO is full, unless a pop occurs in the same cycle; simultaneous push and pop leaves the count unchanged.
REQ-023 SHALL implement FSM states ARB and LOCKED.
  - ARB -> LOCKED on a handshake whose winner has atop_i=1.
  - LOCKED -> ARB on the cycle mgr_rvalid_i pops the FIFO entry for that atomic.
REQ-024 SHALL, in LOCKED, issue no grants to any port, so the atomic's read-modify-write is never interleaved with another request.
REQ-025 SHALL, when the winner has atop_i=1 and the FIFO is non-empty (older responses outstanding), withhold the grant until the FIFO drains to empty; that port keeps priority while it waits.
REQ-026 SHALL track the atomic's FIFO slot so that intervening pops of older entries do not unlock early.
REQ-027 SHALL drive locked_o=1 exactly in LOCKED.
REQ-028 SHALL treat mgr_rvalid_i with an empty FIFO as an error: no pop, rvalid_o=0, simulation assertion fires.
REQ-029 SHALL assert in simulation that req_i[k] is not dropped before gnt_o[k].

Reset
REQ-030 SHALL, while rst_i=1 at a clock edge, clear FSM to ARB, FIFO pointers and count to 0, and priority pointer to 0.
REQ-031 SHALL force mgr_req_o=0, gnt_o=0, rvalid_o=0, locked_o=0, sel_o=0 and rsel_o=0 during reset.
REQ-032 SHALL, on reset asserted mid-transaction, discard all outstanding entries with no responses routed afterwards.

Structure
REQ-033 SHALL place the FSM state enum (ARB, LOCKED) in obi_pkg.
REQ-034 SHALL use one sub-module, fifo_v3, for the ID FIFO (DATA_WIDTH = SelWidth, DEPTH = MaxTrans), with flush tied to rst_i.

Verification
REQ-035 SHALL verify: ports 0 and 1 request continuously, non-atomic, mgr_gnt_i=1 -> grants alternate 0,1,0,1; sel_o matches gnt_o.
REQ-036 SHALL verify: port 1 issues an atomic, port 0 requests next cycle, response 3 cycles later -> port 0 not granted until the cycle after rvalid_o[1]; locked_o high for exactly those cycles.
REQ-037 SHALL verify: MaxTrans=4, 4 grants with no rvalid -> mgr_req_o=0 on the 5th; rvalid on that cycle -> 5th grant issued in the same cycle.
REQ-038 SHALL verify: 2 reads outstanding, then port 0 atomic -> no grant until both responses return; then grant, LOCKED.
REQ-039 SHALL verify: responses for a push order 1,0,1 -> rvalid_o sequence 2'b10, 2'b01, 2'b10 with rsel_o 1,0,1.
REQ-040 SHALL verify: rst_i asserted in LOCKED with 2 outstanding -> next cycle all outputs 0, FSM ARB, a fresh request is granted normally.
